// File: rtl/pipe_stage_skid_if.sv
// Valid/ready/data handshake bundle between two pipeline stages.
// The master drives valid and data; the slave drives ready.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 64
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a one-entry skid buffer, a synchronous flush
// and a saturating stall counter. in_ready is a flop, not a function of out_ready.
module pipe_stage_skid #(
  parameter int              DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int              CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  pipe_stage_skid_if.slave  in_if,
  pipe_stage_skid_if.master out_if,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic                in_ready_q, in_ready_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic acc;
  logic drn;
  logic out_valid;

  assign out_valid = (state_q != EMPTY);
  assign acc       = in_if.valid && in_ready_q;
  assign drn       = out_valid && out_if.ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_data_q <= BUBBLE_VAL;
      skid_data_q <= BUBBLE_VAL;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d     = EMPTY;
      main_data_d = BUBBLE_VAL;
      skid_data_d = BUBBLE_VAL;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d     = FULL;
            main_data_d = in_if.data;
          end
        end
        FULL: begin
          if (acc && drn) begin
            main_data_d = in_if.data;
          end else if (acc) begin
            state_d     = SKID;
            skid_data_d = in_if.data;
          end else if (drn) begin
            state_d     = EMPTY;
            main_data_d = BUBBLE_VAL;
          end
        end
        SKID: begin
          if (drn) begin
            state_d     = FULL;
            main_data_d = skid_data_q;
            skid_data_d = BUBBLE_VAL;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_data_d = BUBBLE_VAL;
          skid_data_d = BUBBLE_VAL;
        end
      endcase
    end
    // Registered ready tracks the skid occupancy of the state being entered.
    in_ready_d = (state_d != SKID);

    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_if.ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    out_if.valid = out_valid;
    out_if.data  = main_data_q;
    in_if.ready  = in_ready_q;
    stall_cnt    = stall_cnt_q;
  end

endmodule
